// File: rtl/region_bin_ctrl_if.sv
// Host configuration channel for region_bin_ctrl: valid/ready handshake carrying mode,
// border colour and signed threshold offset.
interface region_bin_ctrl_if;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_mode;
    logic       cfg_edge_white;
    logic [7:0] cfg_offset;

    modport master (
        output cfg_valid,
        output cfg_mode,
        output cfg_edge_white,
        output cfg_offset,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_mode,
        input  cfg_edge_white,
        input  cfg_offset,
        output cfg_ready
    );
endinterface

// File: rtl/region_bin_ctrl.sv
// Frame-level controller for the 5x5 mean-threshold binarization path: latches host config at
// frame start, gates video into the datapath, muxes the output with matched latency, checks geometry.
module region_bin_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int H_DISP      = 1280,
    parameter int V_DISP      = 720,
    parameter int BIN_LATENCY = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    region_bin_ctrl_if.slave      cfg,
    input  logic                  pre_img_vsync,
    input  logic                  pre_img_hsync,
    input  logic                  pre_img_valid,
    input  logic [DATA_WIDTH-1:0] pre_img_data,
    output logic                  bin_img_vsync,
    output logic                  bin_img_hsync,
    output logic                  bin_img_valid,
    output logic [DATA_WIDTH-1:0] bin_img_data,
    input  logic                  bin_post_vsync,
    input  logic                  bin_post_hsync,
    input  logic                  bin_post_valid,
    input  logic [DATA_WIDTH-1:0] bin_post_data,
    output logic                  bin_edge_white,
    output logic [7:0]            bin_thresh_offset,
    output logic                  post_img_vsync,
    output logic                  post_img_hsync,
    output logic                  post_img_valid,
    output logic [DATA_WIDTH-1:0] post_img_data,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  frame_err,
    output logic [15:0]           frame_cnt
);

    localparam int VW = DATA_WIDTH + 3;
    localparam int CW = $clog2(BIN_LATENCY + 2);

    typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DRAIN = 2'd2} state_t;

    state_t          r_state, w_stateNext;
    logic [CW-1:0]   r_drainCnt, w_drainNext;
    logic            r_vsyncD, r_validD;
    logic            w_vsRise, w_vsFall, w_validFall;
    logic            r_pendValid, r_pendEdge, r_actEdge;
    logic [1:0]      r_pendMode, r_actMode;
    logic [7:0]      r_pendOffset, r_actOffset;
    logic [11:0]     r_pixCnt, r_lineCnt;
    logic            r_geomSticky, w_geomErr;
    logic            w_done, w_err, r_frameDone, r_frameErr;
    logic [15:0]     r_frameCnt;
    logic [VW-1:0]   r_dly [BIN_LATENCY];
    logic [VW-1:0]   w_dlyOut, r_post;
    logic            w_binEn;

    assign w_vsRise    = pre_img_vsync & ~r_vsyncD;
    assign w_vsFall    = ~pre_img_vsync & r_vsyncD;
    assign w_validFall = ~pre_img_valid & r_validD;
    assign w_geomErr   = r_geomSticky | (r_lineCnt != 12'(V_DISP));
    assign w_binEn     = (r_actMode == 2'b01);
    assign w_dlyOut    = r_dly[BIN_LATENCY-1];

    assign cfg.cfg_ready     = ~r_pendValid;
    assign bin_edge_white    = r_actEdge;
    assign bin_thresh_offset = r_actOffset;
    assign bin_img_vsync     = w_binEn & pre_img_vsync;
    assign bin_img_hsync     = w_binEn & pre_img_hsync;
    assign bin_img_valid     = w_binEn & pre_img_valid;
    assign bin_img_data      = w_binEn ? pre_img_data : '0;
    assign {post_img_vsync, post_img_hsync, post_img_valid, post_img_data} = r_post;
    assign busy       = (r_state != IDLE);
    assign frame_done = r_frameDone;
    assign frame_err  = r_frameErr;
    assign frame_cnt  = r_frameCnt;

    // vsync history resets high so a frame already in progress at reset release is not a start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vsyncD <= 1'b1;
            r_validD <= 1'b0;
        end else begin
            r_vsyncD <= pre_img_vsync;
            r_validD <= pre_img_valid;
        end
    end

    // A capture can only happen while nothing is pending, so it never collides with the apply
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pendValid  <= 1'b0;
            r_pendMode   <= 2'b00;
            r_pendEdge   <= 1'b0;
            r_pendOffset <= 8'h00;
            r_actMode    <= 2'b00;
            r_actEdge    <= 1'b0;
            r_actOffset  <= 8'h00;
        end else if (w_vsRise && r_pendValid) begin
            r_actMode   <= r_pendMode;
            r_actEdge   <= r_pendEdge;
            r_actOffset <= r_pendOffset;
            r_pendValid <= 1'b0;
        end else if (cfg.cfg_valid && !r_pendValid) begin
            r_pendMode   <= cfg.cfg_mode;
            r_pendEdge   <= cfg.cfg_edge_white;
            r_pendOffset <= cfg.cfg_offset;
            r_pendValid  <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pixCnt     <= '0;
            r_lineCnt    <= '0;
            r_geomSticky <= 1'b0;
        end else if (w_vsRise) begin
            r_pixCnt     <= '0;
            r_lineCnt    <= '0;
            r_geomSticky <= 1'b0;
        end else if (w_validFall) begin
            if (r_pixCnt != 12'(H_DISP)) r_geomSticky <= 1'b1;
            r_pixCnt <= '0;
            if (r_lineCnt != 12'hFFF) r_lineCnt <= r_lineCnt + 12'd1;
        end else if (pre_img_valid && r_pixCnt != 12'hFFF) begin
            r_pixCnt <= r_pixCnt + 12'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_drainCnt  <= '0;
            r_frameDone <= 1'b0;
            r_frameErr  <= 1'b0;
            r_frameCnt  <= '0;
        end else begin
            r_state     <= w_stateNext;
            r_drainCnt  <= w_drainNext;
            r_frameDone <= w_done;
            r_frameErr  <= w_err;
            if (w_done) r_frameCnt <= r_frameCnt + 16'd1;
        end
    end

    // A new frame arriving before the drain finishes closes the old one as erroneous
    always_comb begin
        w_stateNext = r_state;
        w_drainNext = r_drainCnt;
        w_done      = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_vsRise) w_stateNext = ACTIVE;
            end
            ACTIVE: begin
                if (w_vsFall) begin
                    w_stateNext = DRAIN;
                    w_drainNext = CW'(BIN_LATENCY + 1);
                end
            end
            DRAIN: begin
                if (w_vsRise) begin
                    w_done      = 1'b1;
                    w_err       = 1'b1;
                    w_stateNext = ACTIVE;
                end else if (r_drainCnt == '0) begin
                    w_done      = 1'b1;
                    w_err       = w_geomErr;
                    w_stateNext = IDLE;
                end else begin
                    w_drainNext = r_drainCnt - CW'(1);
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BIN_LATENCY; i++) r_dly[i] <= '0;
        end else begin
            r_dly[0] <= {pre_img_vsync, pre_img_hsync, pre_img_valid, pre_img_data};
            for (int i = 1; i < BIN_LATENCY; i++) r_dly[i] <= r_dly[i-1];
        end
    end

    // Bypass paths run through BIN_LATENCY delay stages so every mode sees the same latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_post <= '0;
        end else if (r_state == IDLE) begin
            r_post <= '0;
        end else begin
            case (r_actMode)
                2'b01:   r_post <= {bin_post_vsync, bin_post_hsync, bin_post_valid, bin_post_data};
                2'b00:   r_post <= w_dlyOut;
                default: r_post <= {w_dlyOut[VW-1:DATA_WIDTH], {DATA_WIDTH{1'b0}}};
            endcase
        end
    end

endmodule
